// File: rtl/ft64_amo_unit_if.sv
// Request/response and bus signals of the FT64 atomic-memory-operation unit.
interface ft64_amo_unit_if #(
  parameter int unsigned WID  = 64,
  parameter int unsigned AWID = 32
);
  logic              req_i;
  logic              rdy_o;
  logic [3:0]        op_i;
  logic [2:0]        sz_i;
  logic [AWID-1:0]   adr_i;
  logic [WID-1:0]    b_i;
  logic [WID-1:0]    cmp_i;
  logic              done_o;
  logic              err_o;
  logic [WID-1:0]    old_o;
  logic              cyc_o;
  logic              stb_o;
  logic              lock_o;
  logic              we_o;
  logic [WID/8-1:0]  sel_o;
  logic [AWID-1:0]   adr_o;
  logic [WID-1:0]    dat_o;
  logic [WID-1:0]    dat_i;
  logic              ack_i;
  logic              err_i;

  modport slave (
    input  req_i, op_i, sz_i, adr_i, b_i, cmp_i, dat_i, ack_i, err_i,
    output rdy_o, done_o, err_o, old_o, cyc_o, stb_o, lock_o, we_o, sel_o, adr_o, dat_o
  );

  modport master (
    output req_i, op_i, sz_i, adr_i, b_i, cmp_i, dat_i, ack_i, err_i,
    input  rdy_o, done_o, err_o, old_o, cyc_o, stb_o, lock_o, we_o, sel_o, adr_o, dat_o
  );
endinterface

// File: rtl/ft64_amo_unit.sv
// FT64 atomic-memory-operation engine: locked read-modify-write with a per-lane ALU,
// CAS, bus-error handling and a bus timeout.
module ft64_amo_unit #(
  parameter int unsigned WID  = 64,
  parameter int unsigned AWID = 32,
  parameter int unsigned TMO  = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ft64_amo_unit_if.slave bus
);
  localparam int unsigned NSZ    = $clog2(WID / 8) + 1;
  localparam logic [2:0]  SZ_MAX = 3'(NSZ - 1);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;
  localparam logic [3:0] OP_CAS  = 4'd11;

  typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      sz_q, sz_d;
  logic [AWID-1:0] adr_q, adr_d;
  logic [WID-1:0]  b_q, b_d, cmp_q, cmp_d, old_q, old_d, dat_q, dat_d;
  logic            ill_q, ill_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            rdy_q, rdy_d, done_q, done_d, err_q, err_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, lock_q, lock_d, we_q, we_d;
  logic            bus_err_c;
  logic [WID-1:0]  new_c;
  wire  [WID-1:0]  res_sz [NSZ];

  // One ALU per legal lane width; lanes never exchange carries or shift bits.
  for (genvar s = 0; s < NSZ; s++) begin : g_sz
    localparam int unsigned LW = 8 << s;
    localparam int unsigned SW = $clog2(LW);
    for (genvar l = 0; l < WID / LW; l++) begin : g_lane
      logic [LW-1:0] a, bb, r;
      assign a  = old_q[l*LW +: LW];
      assign bb = b_q[l*LW +: LW];
      always_comb begin
        case (op_q)
          OP_ADD:  r = a + bb;
          OP_AND:  r = a & bb;
          OP_OR:   r = a | bb;
          OP_XOR:  r = a ^ bb;
          OP_SHL:  r = a << b_q[SW-1:0];
          OP_SHR:  r = a >> b_q[SW-1:0];
          OP_MIN:  r = ($signed(a) < $signed(bb)) ? a : bb;
          OP_MAX:  r = ($signed(a) > $signed(bb)) ? a : bb;
          OP_MINU: r = (a < bb) ? a : bb;
          OP_MAXU: r = (a > bb) ? a : bb;
          default: r = bb;
        endcase
      end
      assign res_sz[s][l*LW +: LW] = r;
    end
  end

  always_comb begin
    new_c = b_q;
    for (int s = 0; s < NSZ; s++) begin
      if (sz_q == 3'(s)) new_c = res_sz[s];
    end
  end

  // A stalled strobe that has waited TMO cycles is treated like err_i.
  assign bus_err_c = bus.err_i || (tmo_q == 8'(TMO));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sz_d    = sz_q;
    adr_d   = adr_q;
    b_d     = b_q;
    cmp_d   = cmp_q;
    old_d   = old_q;
    dat_d   = dat_q;
    ill_d   = ill_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          op_d    = bus.op_i;
          sz_d    = bus.sz_i;
          adr_d   = bus.adr_i;
          b_d     = bus.b_i;
          cmp_d   = bus.cmp_i;
          old_d   = '0;
          ill_d   = (bus.op_i > OP_CAS) || (bus.sz_i > SZ_MAX);
          // Illegal requests idle through CALC without a bus cycle.
          state_d = ill_d ? CALC : RD;
        end
      end
      RD: begin
        if (bus_err_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.ack_i) begin
          old_d   = bus.dat_i;
          state_d = CALC;
        end
      end
      CALC: begin
        if (ill_q) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (op_q == OP_CAS && old_q != cmp_q) begin
          state_d = DONE;
        end else begin
          dat_d   = new_c;
          state_d = WR;
        end
      end
      WR: begin
        if (bus_err_c) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.ack_i) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cyc_d  = (state_d == RD) || (state_d == WR) || (state_d == CALC && !ill_d);
    lock_d = cyc_d;
    stb_d  = (state_d == RD) || (state_d == WR);
    we_d   = (state_d == WR);
    rdy_d  = (state_d == IDLE);
    done_d = (state_d == DONE);
    tmo_d  = (state_d != state_q || !stb_q) ? 8'd0 : tmo_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      sz_q    <= '0;
      adr_q   <= '0;
      b_q     <= '0;
      cmp_q   <= '0;
      old_q   <= '0;
      dat_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sz_q    <= sz_d;
      adr_q   <= adr_d;
      b_q     <= b_d;
      cmp_q   <= cmp_d;
      old_q   <= old_d;
      dat_q   <= dat_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      lock_q  <= lock_d;
      we_q    <= we_d;
    end
  end

  assign bus.rdy_o  = rdy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;
  assign bus.old_o  = old_q;
  assign bus.cyc_o  = cyc_q;
  assign bus.stb_o  = stb_q;
  assign bus.lock_o = lock_q;
  assign bus.we_o   = we_q;
  assign bus.sel_o  = '1;
  assign bus.adr_o  = adr_q;
  assign bus.dat_o  = dat_q;
endmodule
